// File: rtl/pcs_10g_tx_gearbox.sv
// pcs_10g_tx_gearbox: packs 66-bit PCS blocks (sync header + scrambled
// payload) into a continuous 64-bit word stream for the SERDES.
// Each 33-cycle sequence absorbs 32 blocks. On the 33rd cycle the upstream
// stage is stalled while the 64 accumulated leftover bits are flushed.
// Optional feature macro: PCS_TX_GEARBOX_UNDERFLOW_CNT_EN adds a saturating
// count of bubble cycles and a registered per-bubble pulse.

module pcs_10g_tx_gearbox #(
    parameter  int DATA_W = 64,
    parameter  int HEAD_W = 2,
    localparam int SEQ_N  = DATA_W / HEAD_W + 1,
    localparam int SEQ_W  = $clog2(SEQ_N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_v_i,
    input  logic [HEAD_W-1:0] sync_head_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              data_v_o,
    output logic [DATA_W-1:0] data_o,
`ifdef PCS_TX_GEARBOX_UNDERFLOW_CNT_EN
    output logic [15:0]       underflow_cnt_o,
    output logic [0:0]        underflow_o,
`endif
    output logic [SEQ_W-1:0]  seq_o
);

    localparam int BLK_W = DATA_W + HEAD_W;
    localparam int PAD_W = 2 * DATA_W - BLK_W;

    logic [SEQ_W-1:0]    r_seq;
    logic [DATA_W-1:0]   r_left;
    logic [DATA_W-1:0]   r_data;
    logic                r_data_v;

    logic [BLK_W-1:0]    w_blk;
    logic                w_stall;
    logic                w_accept;
    logic [SEQ_W:0]      w_shamt;
    logic [2*DATA_W-1:0] w_shift;
    logic [2*DATA_W-1:0] w_packed;

    // Header goes on the wire first, so it occupies the low bits of the block.
    assign w_blk    = {data_i, sync_head_i};
    assign w_stall  = (r_seq == SEQ_W'(SEQ_N - 1));
    assign w_accept = in_v_i & ~w_stall;
    assign ready_o  = ~w_stall;

    // Block lands above the 2*seq leftover bits; header width is fixed at 2,
    // so the shift is seq doubled. The upper half becomes the new leftover.
    assign w_shamt  = {r_seq, 1'b0};
    assign w_shift  = {{PAD_W{1'b0}}, w_blk} << w_shamt;
    assign w_packed = w_shift | {{DATA_W{1'b0}}, r_left};

    // Sequence counter, leftover buffer and output word register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seq    <= '0;
            r_left   <= '0;
            r_data   <= '0;
            r_data_v <= 1'b0;
        end else if (w_stall) begin
            r_data   <= r_left;
            r_data_v <= 1'b1;
            r_left   <= '0;
            r_seq    <= '0;
        end else if (w_accept) begin
            r_data   <= w_packed[DATA_W-1:0];
            r_data_v <= 1'b1;
            r_left   <= w_packed[2*DATA_W-1:DATA_W];
            r_seq    <= r_seq + SEQ_W'(1);
        end else begin
            r_data_v <= 1'b0;
        end
    end

    assign data_o   = r_data;
    assign data_v_o = r_data_v;
    assign seq_o    = r_seq;

`ifdef PCS_TX_GEARBOX_UNDERFLOW_CNT_EN
    logic        r_seen_first;
    logic [15:0] r_uf_cnt;
    logic        r_uf;
    logic        w_bubble;

    // Bubbles only count once traffic has started after reset.
    assign w_bubble = ~w_stall & ~in_v_i & r_seen_first;

    // Underflow tracking: first-block flag, saturating counter, pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seen_first <= 1'b0;
            r_uf_cnt     <= '0;
            r_uf         <= 1'b0;
        end else begin
            if (w_accept)
                r_seen_first <= 1'b1;
            if (w_bubble && (r_uf_cnt != 16'hFFFF))
                r_uf_cnt <= r_uf_cnt + 16'd1;
            r_uf <= w_bubble;
        end
    end

    assign underflow_cnt_o = r_uf_cnt;
    assign underflow_o     = r_uf;
`endif

endmodule

// File: tb/tb_pcs_10g_tx_gearbox.sv
// Testbench for pcs_10g_tx_gearbox: a bit-level scoreboard holds every
// accepted block's 66 bits in wire order, and each valid output word is
// checked against the next 64 bits. A small sequence model predicts seq_o,
// ready_o and data_v_o.

module tb_pcs_10g_tx_gearbox;

    logic        clk;
    logic        reset;
    logic        in_v_i;
    logic [1:0]  sync_head_i;
    logic [63:0] data_i;
    logic        ready_o;
    logic        data_v_o;
    logic [63:0] data_o;
    logic [5:0]  seq_o;
`ifdef PCS_TX_GEARBOX_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt_o;
    logic [0:0]  underflow_o;
`endif

    pcs_10g_tx_gearbox dut (
        .clk         (clk),
        .reset       (reset),
        .in_v_i      (in_v_i),
        .sync_head_i (sync_head_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .data_v_o    (data_v_o),
        .data_o      (data_o),
`ifdef PCS_TX_GEARBOX_UNDERFLOW_CNT_EN
        .underflow_cnt_o (underflow_cnt_o),
        .underflow_o     (underflow_o),
`endif
        .seq_o       (seq_o)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    bit          sb_q[$];
    logic [5:0]  exp_seq;
    logic [63:0] last_exp;
    logic [5:0]  prev_seq;
    int          n_words, n_stall, n_wraps;
    logic        seen_first;
    int          uf_cnt;
    logic        acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict, then check after the edge.
    task automatic step(input logic v, input logic [1:0] sh, input logic [63:0] d,
                        output logic a);
        logic [65:0] blk;
        logic [63:0] w;
        logic        stall;
        logic        exp_uf;
        stall       = (exp_seq == 6'd32);
        in_v_i      = v;
        sync_head_i = sh;
        data_i      = d;
        a           = v && !stall;
        exp_uf      = !v && !stall && seen_first;
        chk("ready", 64'(ready_o), 64'(!stall));
        if (!ready_o) n_stall++;
        if (a) begin
            blk = {d, sh};
            for (int i = 0; i < 66; i++) sb_q.push_back(blk[i]);
            seen_first = 1'b1;
        end
        @(posedge clk);
        #1;
        if (stall) exp_seq = 6'd0;
        else if (a) exp_seq = exp_seq + 6'd1;
        chk("seq", 64'(seq_o), 64'(exp_seq));
        chk("valid", 64'(data_v_o), 64'(a || stall));
        if (data_v_o) n_words++;
        if (prev_seq == 6'd32 && seq_o == 6'd0) n_wraps++;
        prev_seq = seq_o;
        if (a || stall) begin
            if (sb_q.size() < 64) begin
                chk("sb_underrun", 64'(sb_q.size()), 64'd64);
            end else begin
                for (int i = 0; i < 64; i++) w[i] = sb_q.pop_front();
                last_exp = w;
                chk("word", data_o, w);
            end
        end else begin
            chk("hold", data_o, last_exp);
        end
`ifdef PCS_TX_GEARBOX_UNDERFLOW_CNT_EN
        if (exp_uf) uf_cnt++;
        chk("uf_pulse", 64'(underflow_o), 64'(exp_uf));
        chk("uf_cnt", 64'(underflow_cnt_o), 64'(uf_cnt));
`endif
    endtask

    task automatic send_blk(input logic [1:0] sh, input logic [63:0] d);
        logic a;
        a = 1'b0;
        for (int t = 0; t < 3 && !a; t++) step(1'b1, sh, d, a);
        if (!a) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 64'd0, a);
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++)
            send_blk(2'($urandom_range(0, 3)), {$urandom, $urandom});
    endtask

    task automatic do_reset();
        in_v_i      = 1'b0;
        sync_head_i = 2'b00;
        data_i      = 64'd0;
        reset       = 1'b1;
        #1;
        chk("rst_data", data_o, 64'd0);
        chk("rst_valid", 64'(data_v_o), 64'd0);
        chk("rst_seq", 64'(seq_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        exp_seq    = 6'd0;
        prev_seq   = 6'd0;
        last_exp   = 64'd0;
        seen_first = 1'b0;
        uf_cnt     = 0;
    endtask

    initial begin
        logic [1:0]  sh;
        logic [63:0] d;
        clk         = 1'b0;
        reset       = 1'b1;
        in_v_i      = 1'b0;
        sync_head_i = 2'b00;
        data_i      = 64'd0;
        exp_seq     = 6'd0;
        prev_seq    = 6'd0;
        last_exp    = 64'd0;
        seen_first  = 1'b0;
        uf_cnt      = 0;
        n_words = 0; n_stall = 0; n_wraps = 0;
        @(posedge clk);
        #1;

        // Zero payload data blocks: each word exposes the header pattern.
        do_reset();
        send_blk(2'b01, 64'd0);
        chk("t1_w0", data_o, 64'h1);
        send_blk(2'b01, 64'd0);
        chk("t1_w1", data_o, 64'h4);
        for (int i = 0; i < 30; i++) send_blk(2'b01, 64'd0);
        chk("t1_seq32", 64'(seq_o), 64'd32);
        chk("t1_ready0", 64'(ready_o), 64'd0);
        send_blk(2'b01, 64'd0);
        chk("t1_seq_after", 64'(seq_o), 64'd1);

        // 64 random blocks: 66 words, 2 stalls, 2 wraps.
        do_reset();
        n_words = 0; n_stall = 0; n_wraps = 0;
        send_rand(64);
        idle(1);
        chk("t2_words", 64'(n_words), 64'd66);
        chk("t2_stalls", 64'(n_stall), 64'd2);
        chk("t2_wraps", 64'(n_wraps), 64'd2);
        chk("t2_sb_empty", 64'(sb_q.size()), 64'd0);

        // All-ones control block followed by an all-zero block.
        do_reset();
        send_blk(2'b10, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3_w0", data_o, 64'hFFFF_FFFF_FFFF_FFFE);
        send_blk(2'b00, 64'd0);
        chk("t3_w1", data_o, 64'h3);

        // Bubble of 3 cycles at seq 10; stream must stay contiguous.
        do_reset();
        send_rand(10);
        chk("t4_seq10", 64'(seq_o), 64'd10);
        idle(3);
        chk("t4_seq_hold", 64'(seq_o), 64'd10);
        chk("t4_valid0", 64'(data_v_o), 64'd0);
        send_rand(22);
        idle(1);
        chk("t4_sb_empty", 64'(sb_q.size()), 64'd0);

        // Reset in mid-sequence discards leftovers.
        do_reset();
        send_rand(20);
        chk("t5_seq20", 64'(seq_o), 64'd20);
        do_reset();
        sh = 2'($urandom_range(0, 3));
        d  = {$urandom, $urandom};
        send_blk(sh, d);
        chk("t5_first", data_o, {d[61:0], sh});
        chk("t5_seq1", 64'(seq_o), 64'd1);

`ifdef PCS_TX_GEARBOX_UNDERFLOW_CNT_EN
        // Bubbles before the first block are not counted.
        do_reset();
        idle(3);
        chk("t6_pre", 64'(underflow_cnt_o), 64'd0);
        send_rand(1);
        idle(5);
        chk("t6_post", 64'(underflow_cnt_o), 64'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcs_10g_tx_gearbox.md
Name: pcs_10g_tx_gearbox

Overview:
Transmit gearbox that sits directly downstream of the 10G PCS encode stage and its scrambler. It packs 66-bit blocks (2-bit sync header plus 64-bit payload) into a continuous stream of 64-bit words for the SERDES. Every 33 output cycles it absorbs 32 blocks, and it back-pressures the upstream stage for one cycle per sequence.

Parameters:
- DATA_W, 64, payload and output word width. Only 64 is supported.
- HEAD_W, 2, sync header width.
- SEQ_N, 33, output cycles per gearbox sequence. Localparam, equal to DATA_W/HEAD_W+1.
- SEQ_W, 6, sequence counter width. Localparam, $clog2(SEQ_N).

Ports:
- clk  in  1  data clock
- reset  in  1  asynchronous, active-high reset
- in_v_i  in  1  upstream block valid
- sync_head_i  in  2  sync header: 2'b01 data, 2'b10 control
- data_i  in  64  scrambled block payload
- ready_o  out  1  block accepted this cycle when in_v_i & ready_o
- data_v_o  out  1  data_o valid
- data_o  out  64  gearboxed word; bit 0 is transmitted first
- seq_o  out  6  current sequence counter value, for debug and alignment

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous and active-high.
- Reset values: seq_q=0, leftover buffer=0, data_v_o=0, data_o=0. ready_o is combinational (seq_q != 32), so it is 1 out of reset.
- Serial order within a block: sync_head_i[0], sync_head_i[1], then data_i[0..63].
- Sequence counter seq_q runs 0..32.
- For s in 0..31:
  - ready_o=1.
  - On acceptance: data_o <= {blk[63-2s:0], left_q[2s-1:0]}, where blk = {data_i, sync_head_i} (66 bits).
  - left_q <= blk[65:64-2s], i.e. 2(s+1) bits.
  - seq_q <= s+1.
  - For s=0, data_o = blk[63:0] and no leftover bits are used.
- For s=32:
  - ready_o=0.
  - data_o <= left_q[63:0], data_v_o <= 1, seq_q <= 0, left_q cleared.
  - in_v_i is ignored this cycle.
- Bubble: s<32 with in_v_i=0 gives data_v_o <= 0. seq_q and left_q hold, data_o holds its previous value.
- Latency: one cycle from acceptance to data_o/data_v_o.
- Throughput: 32 blocks per 33 cycles when in_v_i is held high.
- Output boundary: left_q width is 64. The wrap from 32 to 0 happens only on the stall cycle.
- sync_head_i is not checked (2'b00/2'b11 pass through unchanged). Checking belongs to the encoder.
- Reset asserted mid-sequence: immediate return to reset values. Any partial leftover is discarded; no flush.
- seq_o = seq_q.

Optional Feature:
- Macro: PCS_TX_GEARBOX_UNDERFLOW_CNT_EN.
- When defined:
  - Adds output underflow_cnt_o [15:0]: a saturating count of bubble cycles (s<32 & ~in_v_i) occurring after the first accepted block since reset.
  - Adds output underflow_o [0:0], registered, pulsed on each such bubble.
  - Counter resets to 0 and saturates at 16'hFFFF.
- When undefined: neither port nor any of the logic exists. Behaviour is otherwise identical.

Test Plan:
- Reset then in_v_i=1, blocks k=0.. with sync_head=2'b01, data=64'h0 -> cycle 1: data_o=64'h1, data_v_o=1; cycle 2: data_o=64'h4; ready_o=0 exactly on every 33rd cycle (seq_o=32).
- Stream 64 random blocks -> serialising data_o (bit 0 first) equals the concatenation of the 66-bit inputs bit-exact; 66 data_v_o words, 2 stall cycles, seq_o wraps 32->0 twice.
- Block 0 = {data_i=64'hFFFF_FFFF_FFFF_FFFF, sync_head=2'b10} then zeros -> word0=64'hFFFF_FFFF_FFFF_FFFE, word1=64'h3.
- Drop in_v_i for 3 cycles at seq_o=10 -> data_v_o=0 for 3 cycles, seq_o stays 10, and the serial stream stays contiguous once in_v_i returns.
- Assert reset at seq_o=20 for 1 cycle, then stream again -> outputs zero immediately; next word is the new block's low 64 bits with seq_o=0→1.
- With PCS_TX_GEARBOX_UNDERFLOW_CNT_EN: 5 bubbles after the first block -> underflow_cnt_o=5; bubbles before the first block are not counted (count stays 0).
